fw_dut_cfg_responder: RTL and testbench

//  Synthesizable DUT-side emulator of the CMS pix28 configuration shift chain: receives the FW-driven

---
 rtl/cms_pix28_package.sv | 24 ++
 rtl/fw_edge_det.sv | 33 +++
 rtl/fw_dut_cfg_responder.sv | 183 ++++++++++++++++++
 tb/tb_fw_dut_cfg_responder.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cms_pix28_package.sv
// Shared constants for the pix28 configuration-chain emulator: chain length,
// sticky status bit positions and the order/idle levels of the sampled inputs.
package cms_pix28_package;

   localparam int CFG_CHAIN_LEN = 768;

   // Sticky status flag bit positions
   localparam int STATUS_OVF    = 0;
   localparam int STATUS_SHORT  = 1;
   localparam int STATUS_SELERR = 2;
   localparam int STATUS_W      = 3;

   // Sampled-input slots, one edge detector each
   localparam int IN_CLK  = 0;
   localparam int IN_LOAD = 1;
   localparam int IN_RSTN = 2;
   localparam int IN_SEL  = 3;
   localparam int IN_DATA = 4;
   localparam int IN_NUM  = 5;

   // Idle level of each input: config_load and reset_not idle high
   localparam logic [IN_NUM-1:0] IN_IDLE = 5'b00110;

endpackage

// File: rtl/fw_edge_det.sv
// One input register stage plus a previous-value register; produces the
// registered level and single-cycle rise/fall pulses. Both registers reset
// to the idle level so releasing reset never looks like an edge.
module fw_edge_det #(
   parameter logic IDLE = 1'b0
) (
   input  logic clk,
   input  logic srst,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic cur_reg;
   logic prev_reg;

   // Sample the input, keep one cycle of history for edge detection
   always_ff @(posedge clk) begin
      if (srst) begin
         cur_reg  <= IDLE;
         prev_reg <= IDLE;
      end else begin
         cur_reg  <= din;
         prev_reg <= cur_reg;
      end
   end

   assign level = cur_reg;
   assign rise  = cur_reg & ~prev_reg;
   assign fall  = ~cur_reg & prev_reg;

endmodule

// File: rtl/fw_dut_cfg_responder.sv
// Chip-side emulator of the pix28 config shift chain. Two bank shift
// registers are fed from the serial config port; a config_load rise commits
// the active bank, reports the bit count and updates sticky status flags.
module fw_dut_cfg_responder
   import cms_pix28_package::*;
#(
   parameter int CHAIN_LEN = CFG_CHAIN_LEN,
   parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
   input  logic                 fw_clk,
   input  logic                 fw_rst,
   input  logic                 fw_super_pixel_sel,
   input  logic                 fw_config_clk,
   input  logic                 fw_config_in,
   input  logic                 fw_config_load,
   input  logic                 fw_reset_not,
   output logic                 fw_config_out,
   output logic [CHAIN_LEN-1:0] cfg_bank0_q,
   output logic [CHAIN_LEN-1:0] cfg_bank1_q,
   output logic                 load_done,
   output logic                 load_bank,
   output logic [CNT_W-1:0]     load_count,
   input  logic                 status_clear,
   output logic [STATUS_W-1:0]  status_flags
);

   logic [IN_NUM-1:0] raw;
   logic [IN_NUM-1:0] lvl;
   logic [IN_NUM-1:0] rise;
   logic [IN_NUM-1:0] fall;

   assign raw[IN_CLK]  = fw_config_clk;
   assign raw[IN_LOAD] = fw_config_load;
   assign raw[IN_RSTN] = fw_reset_not;
   assign raw[IN_SEL]  = fw_super_pixel_sel;
   assign raw[IN_DATA] = fw_config_in;

   generate
      for (genvar gi = 0; gi < IN_NUM; gi++) begin : g_in
         fw_edge_det #(
            .IDLE (IN_IDLE[gi])
         ) u_det (
            .clk   (fw_clk),
            .srst  (fw_rst),
            .din   (raw[gi]),
            .level (lvl[gi]),
            .rise  (rise[gi]),
            .fall  (fall[gi])
         );
      end
   endgenerate

   logic clk_rise;
   logic load_rise;
   logic chip_rst;
   logic sel;
   logic din;

   assign clk_rise  = rise[IN_CLK];
   assign load_rise = rise[IN_LOAD];
   assign chip_rst  = ~lvl[IN_RSTN];
   assign sel       = lvl[IN_SEL];
   assign din       = lvl[IN_DATA];

   // Edge/level outputs this block has no use for
   logic unused_edges;
   assign unused_edges = ^{lvl[IN_CLK], lvl[IN_LOAD], rise[IN_RSTN],
                           rise[IN_SEL], rise[IN_DATA], fall};

   logic                 frame_active_reg;
   logic                 frame_bank_reg;
   logic [CNT_W-1:0]     bit_cnt_reg;
   logic [CNT_W-1:0]     cnt_next;
   logic                 load_done_reg;
   logic                 load_bank_reg;
   logic [CNT_W-1:0]     load_count_reg;
   logic [STATUS_W-1:0]  flags_reg;
   logic [STATUS_W-1:0]  flags_next;
   logic                 bank_eff;
   logic                 cnt_full;
   logic                 ev_ovf;
   logic                 ev_short;
   logic                 ev_sel;
   logic [1:0]           msb;
   logic [CHAIN_LEN-1:0] cfg_q [2];

   // Bank routing, saturating count and flag events for this cycle
   always_comb begin
      bank_eff = frame_active_reg ? frame_bank_reg : sel;
      cnt_full = (bit_cnt_reg == CNT_W'(CHAIN_LEN));
      cnt_next = bit_cnt_reg;
      if (clk_rise && !cnt_full) begin
         cnt_next = bit_cnt_reg + CNT_W'(1);
      end
      ev_ovf   = !chip_rst && clk_rise && cnt_full;
      ev_short = !chip_rst && load_rise && (cnt_next != CNT_W'(CHAIN_LEN));
      ev_sel   = !chip_rst && frame_active_reg && (sel != frame_bank_reg);
      flags_next = flags_reg & ~{STATUS_W{status_clear}};
      flags_next[STATUS_OVF]    = flags_next[STATUS_OVF]    | ev_ovf;
      flags_next[STATUS_SHORT]  = flags_next[STATUS_SHORT]  | ev_short;
      flags_next[STATUS_SELERR] = flags_next[STATUS_SELERR] | ev_sel;
   end

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_bank
         localparam logic BANK = (gi != 0);
         logic [CHAIN_LEN-1:0] sr_reg;
         logic [CHAIN_LEN-1:0] sr_shift;
         logic [CHAIN_LEN-1:0] cfg_q_reg;
         logic                 hit;

         assign hit      = (bank_eff == BANK);
         assign sr_shift = {sr_reg[CHAIN_LEN-2:0], din};

         // Shift only the bank this frame is routed to
         always_ff @(posedge fw_clk) begin
            if (fw_rst || chip_rst) begin
               sr_reg <= '0;
            end else if (clk_rise && hit) begin
               sr_reg <= sr_shift;
            end
         end

         // Commit captures the post-shift value when a rise lands on the same cycle
         always_ff @(posedge fw_clk) begin
            if (fw_rst || chip_rst) begin
               cfg_q_reg <= '0;
            end else if (load_rise && hit) begin
               cfg_q_reg <= clk_rise ? sr_shift : sr_reg;
            end
         end

         assign msb[gi]   = sr_reg[CHAIN_LEN-1];
         assign cfg_q[gi] = cfg_q_reg;
      end
   endgenerate

   // Frame tracking, commit reporting and sticky status
   always_ff @(posedge fw_clk) begin
      if (fw_rst) begin
         frame_active_reg <= 1'b0;
         frame_bank_reg   <= 1'b0;
         bit_cnt_reg      <= '0;
         load_done_reg    <= 1'b0;
         load_bank_reg    <= 1'b0;
         load_count_reg   <= '0;
         flags_reg        <= '0;
      end else if (chip_rst) begin
         frame_active_reg <= 1'b0;
         frame_bank_reg   <= 1'b0;
         bit_cnt_reg      <= '0;
         load_done_reg    <= 1'b0;
         load_bank_reg    <= 1'b0;
         load_count_reg   <= '0;
         flags_reg        <= flags_next;
      end else begin
         load_done_reg <= 1'b0;
         flags_reg     <= flags_next;
         if (load_rise) begin
            load_done_reg    <= 1'b1;
            load_bank_reg    <= bank_eff;
            load_count_reg   <= cnt_next;
            bit_cnt_reg      <= '0;
            frame_active_reg <= 1'b0;
         end else begin
            bit_cnt_reg <= cnt_next;
            if (clk_rise) begin
               frame_active_reg <= 1'b1;
               frame_bank_reg   <= bank_eff;
            end
         end
      end
   end

   assign fw_config_out = msb[bank_eff];
   assign cfg_bank0_q   = cfg_q[0];
   assign cfg_bank1_q   = cfg_q[1];
   assign load_done     = load_done_reg;
   assign load_bank     = load_bank_reg;
   assign load_count    = load_count_reg;
   assign status_flags  = flags_reg;

endmodule

// File: tb/tb_fw_dut_cfg_responder.sv
// Directed bench for the pix28 config-chain emulator: full frame, loopback
// with overflow, short frame, same-cycle shift+commit, chip reset, sel glitch,
// FW reset mid-frame and a zero-edge commit.
module tb_fw_dut_cfg_responder;

   localparam int L = 768;

   logic         clk;
   logic         fw_rst;
   logic         sel;
   logic         config_clk;
   logic         config_in;
   logic         config_load;
   logic         reset_not;
   logic         config_out;
   logic [L-1:0] cfg0;
   logic [L-1:0] cfg1;
   logic         load_done;
   logic         load_bank;
   logic [9:0]   load_count;
   logic         status_clear;
   logic [2:0]   flags;

   int n_vec = 0;
   int n_bad = 0;

   fw_dut_cfg_responder dut (
      .fw_clk             (clk),
      .fw_rst             (fw_rst),
      .fw_super_pixel_sel (sel),
      .fw_config_clk      (config_clk),
      .fw_config_in       (config_in),
      .fw_config_load     (config_load),
      .fw_reset_not       (reset_not),
      .fw_config_out      (config_out),
      .cfg_bank0_q        (cfg0),
      .cfg_bank1_q        (cfg1),
      .load_done          (load_done),
      .load_bank          (load_bank),
      .load_count         (load_count),
      .status_clear       (status_clear),
      .status_flags       (flags)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      assert (got === exp) else begin
         n_bad++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic chk_w(input string tag, input logic [L-1:0] got, input logic [L-1:0] exp);
      int k;
      k = 0;
      n_vec++;
      assert (got === exp) else begin
         n_bad++;
         for (int i = 11; i >= 0; i--) begin
            if (got[i*64 +: 64] !== exp[i*64 +: 64]) k = i;
         end
         $error("FAIL %s chunk%0d got=%h exp=%h", tag, k, got[k*64 +: 64], exp[k*64 +: 64]);
      end
   endtask

   task automatic shift_bit(input logic b);
      config_clk = 1'b1;
      config_in  = b;
      tick();
      config_clk = 1'b0;
      tick();
   endtask

   // Shift nbits of a repeating byte, MSB first
   task automatic shift_rep(input logic [7:0] byt, input int nbits);
      for (int i = 0; i < nbits; i++) shift_bit(byt[7 - (i % 8)]);
   endtask

   // Raise config_load (optionally with a final config_clk rise) and check the commit
   task automatic do_commit(input string tag, input logic with_bit, input logic b,
                            input logic clr, input logic exp_bank, input int exp_cnt,
                            input logic [2:0] exp_flags);
      config_load = 1'b1;
      if (with_bit) begin
         config_clk = 1'b1;
         config_in  = b;
      end
      tick();
      config_clk = 1'b0;
      chk({tag, ".done_early"}, 32'(load_done), 32'd0);
      status_clear = clr;
      tick();
      status_clear = 1'b0;
      chk({tag, ".done"}, 32'(load_done), 32'd1);
      chk({tag, ".bank"}, 32'(load_bank), 32'(exp_bank));
      chk({tag, ".count"}, 32'(load_count), 32'(exp_cnt));
      chk({tag, ".flags"}, 32'(flags), 32'(exp_flags));
      tick();
      chk({tag, ".done_end"}, 32'(load_done), 32'd0);
   endtask

   logic [15:0]  w;
   logic [7:0]   flt;
   logic [99:0]  dat;
   logic [L-1:0] base;
   logic [L-1:0] expv;
   logic         b;

   initial begin
      fw_rst       = 1'b1;
      sel          = 1'b0;
      config_clk   = 1'b0;
      config_in    = 1'b0;
      config_load  = 1'b1;
      reset_not    = 1'b1;
      status_clear = 1'b0;
      tick(); tick(); tick();

      // Reset state
      chk("rst.out", 32'(config_out), 32'd0);
      chk("rst.done", 32'(load_done), 32'd0);
      chk("rst.flags", 32'(flags), 32'd0);
      chk("rst.count", 32'(load_count), 32'd0);
      chk_w("rst.cfg0", cfg0, '0);
      chk_w("rst.cfg1", cfg1, '0);
      fw_rst = 1'b0;
      tick(); tick();
      chk("rst.release_done", 32'(load_done), 32'd0);

      // 1: full frame into bank0
      config_load = 1'b0;
      tick();
      shift_rep(8'hA5, L);
      chk_w("t1.hold_before_commit", cfg0, '0);
      chk("t1.out_msb", 32'(config_out), 32'd1);
      do_commit("t1", 1'b0, 1'b0, 1'b0, 1'b0, L, 3'b000);
      chk_w("t1.cfg0", cfg0, {96{8'hA5}});
      chk_w("t1.cfg1", cfg1, '0);
      chk("t1.out_idle_sel0", 32'(config_out), 32'd1);

      // 2: loopback on bank1 with overflow
      sel = 1'b1;
      tick(); tick();
      chk("t2.out_idle_sel1", 32'(config_out), 32'd0);
      config_load = 1'b0;
      tick();
      w   = 16'hC35A;
      flt = 8'h3C;
      for (int i = 0; i < 16; i++) shift_bit(w[15 - i]);
      for (int f = 0; f < 752; f++) shift_bit(flt[7 - (f % 8)]);
      chk("t2.loop0", 32'(config_out), 32'(w[15]));
      for (int f = 752; f < 768; f++) begin
         shift_bit(flt[7 - (f % 8)]);
         chk($sformatf("t2.loop%0d", f - 751), 32'(config_out),
             32'((f - 751 <= 15) ? w[15 - (f - 751)] : 1'b0));
      end
      chk("t2.ovf_flag", 32'(flags), 32'b001);
      do_commit("t2", 1'b0, 1'b0, 1'b0, 1'b1, L, 3'b001);
      chk_w("t2.cfg1", cfg1, {96{8'h3C}});
      chk_w("t2.cfg0_kept", cfg0, {96{8'hA5}});
      status_clear = 1'b1;
      tick();
      status_clear = 1'b0;
      chk("t2.cleared", 32'(flags), 32'd0);

      // 3: short frame of 100 bits into bank0; clear coincides with the flag event
      sel = 1'b0;
      tick(); tick();
      config_load = 1'b0;
      tick();
      dat = '0;
      for (int i = 0; i < 100; i++) begin
         b = ((i % 3) == 0);
         dat[99 - i] = b;
         shift_bit(b);
      end
      base = {96{8'hA5}};
      expv = (base << 100) | {668'b0, dat};
      do_commit("t3", 1'b0, 1'b0, 1'b1, 1'b0, 100, 3'b010);
      chk_w("t3.cfg0", cfg0, expv);
      status_clear = 1'b1;
      tick();
      status_clear = 1'b0;
      chk("t3.cleared", 32'(flags), 32'd0);

      // 4: last config_clk rise on the same cycle as the load rise
      config_load = 1'b0;
      tick();
      shift_rep(8'h5B, L - 1);
      do_commit("t4", 1'b1, 1'b1, 1'b0, 1'b0, L, 3'b000);
      chk_w("t4.cfg0", cfg0, {96{8'h5B}});

      // 5: reset_not pulse mid-frame, load rise while low is ignored
      config_load = 1'b0;
      tick();
      shift_rep(8'hE1, 300);
      reset_not = 1'b0;
      tick(); tick();
      chk_w("t5.cfg0_clr", cfg0, '0);
      chk_w("t5.cfg1_clr", cfg1, '0);
      chk("t5.count_clr", 32'(load_count), 32'd0);
      config_load = 1'b1;
      tick();
      chk("t5.no_done_a", 32'(load_done), 32'd0);
      tick();
      chk("t5.no_done_b", 32'(load_done), 32'd0);
      reset_not = 1'b1;
      tick();
      chk("t5.no_done_c", 32'(load_done), 32'd0);
      tick();
      chk("t5.no_done_d", 32'(load_done), 32'd0);
      config_load = 1'b0;
      tick();
      shift_rep(8'hE1, L);
      do_commit("t5", 1'b0, 1'b0, 1'b0, 1'b0, L, 3'b000);
      chk_w("t5.cfg0", cfg0, {96{8'hE1}});

      // 6: sel glitch mid-frame; bits stay in the latched bank1
      sel = 1'b1;
      tick(); tick();
      config_load = 1'b0;
      tick();
      w = 16'hBEEF;
      for (int i = 0; i < 16; i++) begin
         if (i == 4) sel = 1'b0;
         shift_bit(w[15 - i]);
      end
      do_commit("t6", 1'b0, 1'b0, 1'b0, 1'b1, 16, 3'b110);
      chk_w("t6.cfg1", cfg1, {752'b0, 16'hBEEF});
      chk_w("t6.cfg0_kept", cfg0, {96{8'hE1}});

      // 5b: FW reset mid-frame clears everything on the next cycle
      config_load = 1'b0;
      tick();
      shift_rep(8'h77, 300);
      fw_rst = 1'b1;
      tick();
      fw_rst = 1'b0;
      chk_w("t5b.cfg0", cfg0, '0);
      chk_w("t5b.cfg1", cfg1, '0);
      chk("t5b.out", 32'(config_out), 32'd0);
      chk("t5b.flags", 32'(flags), 32'd0);
      chk("t5b.count", 32'(load_count), 32'd0);
      chk("t5b.bank", 32'(load_bank), 32'd0);
      chk("t5b.done", 32'(load_done), 32'd0);
      tick(); tick(); tick();
      chk("t5b.no_spurious", 32'(load_done), 32'd0);

      // Zero-edge commit is still a commit
      do_commit("t7", 1'b0, 1'b0, 1'b0, 1'b0, 0, 3'b010);
      chk_w("t7.cfg0", cfg0, '0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
